// File: rtl/test_monitor.sv
// test_monitor: bus-mapped bring-up peripheral latching a test verdict and signature,
// raising done/pass after a drain interval. Watchdog built only with TEST_MONITOR_WDOG_EN.
module test_monitor #(
    parameter int unsigned DRAIN_CYCLES = 50,
    parameter logic [31:0] WDOG_DEFAULT = 32'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout,
    output logic [31:0] signature
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef TEST_MONITOR_WDOG_EN
    localparam logic [1:0] ST_TIMEOUT = 2'd3;
`endif

    localparam logic [1:0] REG_RESULT = 2'd0;
    localparam logic [1:0] REG_SIG    = 2'd1;
    localparam logic [1:0] REG_CYCLE  = 2'd2;
    localparam logic [1:0] REG_WDOG   = 2'd3;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q;
    logic [31:0]      cycle_q, cycle_next;
    logic [31:0]      sig_q;
    logic             pass_q;
    logic [30:0]      fail_code_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic [31:0]      rd_mux;
    logic [31:0]      wdog_rd;
    logic             wdog_expired;
    logic             running;
    logic             wr_en, rd_en, result_hit;
    logic [1:0]       reg_sel;
    logic             unused_addr_bits;

    assign req_ready        = 1'b1;
    assign wr_en            = req_valid & req_we;
    assign rd_en            = req_valid & ~req_we;
    assign reg_sel          = req_addr[3:2];
    assign unused_addr_bits = ^req_addr[1:0];

    // Only the first odd verdict in RUN counts; even values (including 0) are ignored.
    assign result_hit = wr_en && (reg_sel == REG_RESULT) && (state_q == ST_RUN) && req_wdata[0];

    assign running    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign cycle_next = (running && (cycle_q != 32'hFFFF_FFFF)) ? cycle_q + 32'd1 : cycle_q;

`ifdef TEST_MONITOR_WDOG_EN
    logic [31:0] wdog_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= WDOG_DEFAULT;
        end else if (wr_en && (reg_sel == REG_WDOG)) begin
            wdog_q <= req_wdata;
        end
    end

    // Compare against the count this edge produces, so expiry lands as CYCLE reaches WDOG.
    assign wdog_expired = (cycle_next >= wdog_q);
    assign wdog_rd      = wdog_q;
    assign timeout      = (state_q == ST_TIMEOUT);
`else
    localparam logic [31:0] unused_wdog_default = WDOG_DEFAULT;

    assign wdog_expired = 1'b0;
    assign wdog_rd      = 32'd0;
    assign timeout      = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (result_hit) begin
                    state_d = ST_DRAIN;
                end else if (wdog_expired) begin
`ifdef TEST_MONITOR_WDOG_EN
                    state_d = ST_TIMEOUT;
`endif
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else if (wdog_expired) begin
`ifdef TEST_MONITOR_WDOG_EN
                    state_d = ST_TIMEOUT;
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            REG_RESULT: rd_mux = {fail_code_q, (state_q == ST_RUN) ? pass_q : done};
            REG_SIG:    rd_mux = sig_q;
            REG_CYCLE:  rd_mux = cycle_q;
            REG_WDOG:   rd_mux = wdog_rd;
            default:    rd_mux = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            cycle_q     <= 32'd0;
            sig_q       <= 32'd0;
            pass_q      <= 1'b0;
            fail_code_q <= 31'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_next;
            if (result_hit) begin
                pass_q      <= (req_wdata == 32'd1);
                fail_code_q <= req_wdata[31:1];
                drain_cnt_q <= DRAIN_LOAD;
            end else if ((state_q == ST_DRAIN) && (drain_cnt_q != '0)) begin
                drain_cnt_q <= drain_cnt_q - CNT_W'(1);
            end
            if (wr_en && (reg_sel == REG_SIG)) begin
                sig_q <= req_wdata;
            end
            rsp_valid_q <= rd_en;
            if (rd_en) begin
                rsp_rdata_q <= rd_mux;
            end
        end
    end

    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign fail_code = fail_code_q;
    assign signature = sig_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
